// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, ready/read holding register and error pulses
module uart_rx #(
    parameter int SYS_CLK_RATE = 2,
    parameter int BAUD_RATE    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_i,
    output logic [7:0] rx_reg,
    output logic       rx_ready,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int N  = SYS_CLK_RATE / BAUD_RATE;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          sync1;
    logic          rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            rx_reg    <= 8'h00;
            rx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A good completion below overrides this clear on the same edge.
            if (rd_i)
                rx_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (idx == 3'd7)
                            state <= STOP;
                        else
                            idx <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (rx_s) begin
                            rx_reg   <= shift;
                            rx_valid <= 1'b1;
                            rx_ready <= 1'b1;
                            overrun  <= rx_ready & ~rd_i;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at N=2 and N=8
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rd_i;
    logic [7:0] rx_reg;
    logic       rx_ready, rx_valid, rx_busy, frame_err, overrun;
    logic       rx8;
    logic [7:0] rx_reg8;
    logic       rx_ready8, rx_valid8, rx_busy8, frame_err8, overrun8;

    int compared   = 0;
    int mismatched = 0;
    int cyc = 0;
    int e0  = 0;
    int valid_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, valid_cyc = -1, ovr_cyc = -1;
    int v8_cnt = 0, f8_cnt = 0;
    logic [7:0] bytes[$];

    uart_rx #(.SYS_CLK_RATE(2), .BAUD_RATE(1)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_i(rd_i), .rx_reg(rx_reg),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_busy(rx_busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    uart_rx #(.SYS_CLK_RATE(8), .BAUD_RATE(1)) dut8 (
        .clk(clk), .rst(rst), .rx(rx8), .rd_i(1'b0), .rx_reg(rx_reg8),
        .rx_ready(rx_ready8), .rx_valid(rx_valid8), .rx_busy(rx_busy8),
        .frame_err(frame_err8), .overrun(overrun8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            bytes.push_back(rx_reg);
        end
        if (frame_err) ferr_cnt++;
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (rx_valid8) v8_cnt++;
        if (frame_err8) f8_cnt++;
    end

    // Caller is at a falling edge; drives one N=2 frame, returns with the line idle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        e0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (2) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        compared++;
        if ({rx_reg, rx_ready, rx_valid, rx_busy, frame_err, overrun} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset_n2: got %h expected 0000", {rx_reg, rx_ready, rx_valid, rx_busy, frame_err, overrun});
        end
        compared++;
        if ({rx_reg8, rx_ready8, rx_valid8, rx_busy8, frame_err8, overrun8} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset_n8: got %h expected 0000", {rx_reg8, rx_ready8, rx_valid8, rx_busy8, frame_err8, overrun8});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_ff;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hFF, 1'b1);
        repeat (6) @(negedge clk);
        compared++;
        if (valid_cnt - v0 !== 1) begin
            mismatched++;
            $display("FAIL ff_valid_count: got %0d expected 1", valid_cnt - v0);
        end
        compared++;
        if (valid_cyc !== e0 + 21) begin
            mismatched++;
            $display("FAIL ff_valid_edge: got E0+%0d expected E0+21", valid_cyc - e0);
        end
        compared++;
        if (rx_reg !== 8'hFF || rx_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ff_data: got reg %h ready %b expected FF 1", rx_reg, rx_ready);
        end
        compared++;
        if (ferr_cnt - f0 !== 0) begin
            mismatched++;
            $display("FAIL ff_frame_err: got %0d expected 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_back_to_back;
        int o0;
        rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        compared++;
        if (rx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_clear: got ready %b expected 0", rx_ready);
        end
        o0 = ovr_cnt;
        bytes.delete();
        send_frame(8'hAA, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (6) @(negedge clk);
        compared++;
        if (bytes.size() !== 2) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d expected 2", bytes.size());
        end else begin
            compared++;
            if (bytes[0] !== 8'hAA || bytes[1] !== 8'h55) begin
                mismatched++;
                $display("FAIL b2b_bytes: got %h %h expected AA 55", bytes[0], bytes[1]);
            end
        end
        compared++;
        if (ovr_cnt - o0 !== 1 || ovr_cyc !== e0 + 21) begin
            mismatched++;
            $display("FAIL b2b_overrun: got %0d at E0+%0d expected 1 at E0+21", ovr_cnt - o0, ovr_cyc - e0);
        end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (6) @(negedge clk);
        compared++;
        if (ferr_cnt - f0 !== 1 || valid_cnt - v0 !== 0) begin
            mismatched++;
            $display("FAIL ferr_pulses: got ferr %0d valid %0d expected 1 0", ferr_cnt - f0, valid_cnt - v0);
        end
        compared++;
        if (rx_reg !== 8'h55 || rx_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ferr_hold: got reg %h ready %b expected 55 1", rx_reg, rx_ready);
        end
        send_frame(8'hC3, 1'b1);
        repeat (6) @(negedge clk);
        compared++;
        if (valid_cnt - v0 !== 1 || rx_reg !== 8'hC3) begin
            mismatched++;
            $display("FAIL ferr_recover: got valid %0d reg %h expected 1 C3", valid_cnt - v0, rx_reg);
        end
    endtask

    task automatic test_rd_on_complete;
        send_frame(8'h5A, 1'b1);
        // Now at the falling edge with cyc == E0+19.
        @(negedge clk);
        rd_i = 1'b1;
        @(negedge clk);
        compared++;
        if (rx_valid !== 1'b1 || rx_ready !== 1'b1 || overrun !== 1'b0 || rx_reg !== 8'h5A) begin
            mismatched++;
            $display("FAIL rd_complete: got valid %b ready %b ovr %b reg %h expected 1 1 0 5A", rx_valid, rx_ready, overrun, rx_reg);
        end
        @(negedge clk);
        rd_i = 1'b0;
        compared++;
        if (rx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rd_clear: got ready %b expected 0", rx_ready);
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = v8_cnt; f0 = f8_cnt;
        e0 = cyc + 1;
        rx8 = 1'b0;
        @(negedge clk);
        rx8 = 1'b1;
        while (cyc < e0 + 2) @(negedge clk);
        compared++;
        if (rx_busy8 !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch_busy_rise: got %b expected 1", rx_busy8);
        end
        while (cyc < e0 + 5) @(negedge clk);
        compared++;
        if (rx_busy8 !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch_busy_hold: got %b expected 1", rx_busy8);
        end
        @(negedge clk);
        compared++;
        if (rx_busy8 !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_idle: got busy %b expected 0", rx_busy8);
        end
        repeat (100) @(negedge clk);
        compared++;
        if (v8_cnt - v0 !== 0 || f8_cnt - f0 !== 0 || rx_busy8 !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_quiet: got valid %0d ferr %0d busy %b expected 0 0 0", v8_cnt - v0, f8_cnt - f0, rx_busy8);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        int v0, f0, o0;
        b = 8'h81;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (2) @(negedge clk);
        end
        rx = b[4];
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({rx_reg, rx_ready, rx_valid, rx_busy, frame_err, overrun} !== 13'h0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got %h expected 0000", {rx_reg, rx_ready, rx_valid, rx_busy, frame_err, overrun});
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        repeat (30) @(negedge clk);
        compared++;
        if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0 || rx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_quiet: got valid %0d ferr %0d ovr %0d busy %b expected 0 0 0 0", valid_cnt - v0, ferr_cnt - f0, ovr_cnt - o0, rx_busy);
        end
        send_frame(8'h81, 1'b1);
        repeat (6) @(negedge clk);
        compared++;
        if (valid_cnt - v0 !== 1 || rx_reg !== 8'h81 || rx_ready !== 1'b1 || ovr_cnt - o0 !== 0) begin
            mismatched++;
            $display("FAIL midreset_recover: got valid %0d reg %h ready %b ovr %0d expected 1 81 1 0", valid_cnt - v0, rx_reg, rx_ready, ovr_cnt - o0);
        end
    endtask

    initial begin
        rst  = 1'b0;
        rx   = 1'b1;
        rx8  = 1'b1;
        rd_i = 1'b0;
        test_reset();
        test_single_ff();
        test_back_to_back();
        test_frame_err();
        test_rd_on_complete();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
